// File: rtl/tempsens_vdac_sar_ctrl.sv
// tempsens_vdac_sar_ctrl: SAR loop driving the tempsens DAC from delay-line late/early verdicts
module tempsens_vdac_sar_ctrl #(
    parameter int DAC_BITS       = 6,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_meas_done,
    input  logic                i_meas_late,
    output logic [DAC_BITS-1:0] o_dac_data,
    output logic                o_dac_enable,
    output logic                o_meas_start,
    output logic                o_busy,
    output logic [DAC_BITS-1:0] o_result,
    output logic                o_result_valid,
    output logic                o_timeout
);
    localparam int BW = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [DAC_BITS-1:0] code_q, code_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [7:0]          set_cnt_q, set_cnt_d;
    logic [15:0]         to_cnt_q, to_cnt_d;
    logic [DAC_BITS-1:0] result_q, result_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, meas_start_q, valid_q;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        bit_d     = bit_q;
        set_cnt_d = set_cnt_q;
        to_cnt_d  = to_cnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                state_d                = S_SETTLE;
                code_d                 = '0;
                code_d[DAC_BITS-1]     = 1'b1;
                bit_d                  = BW'(DAC_BITS - 1);
                set_cnt_d              = '0;
                timeout_d              = 1'b0;
            end
            S_SETTLE: begin
                set_cnt_d = set_cnt_q + 8'd1;
                state_d   = (set_cnt_q == 8'(SETTLE_CYCLES - 1)) ? S_START : S_SETTLE;
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_q + 16'd1;
                // The START cycle counts toward the timeout window, hence the -2
                if (i_meas_done) begin
                    code_d[bit_q] = i_meas_late;
                    if (bit_q != '0) begin
                        code_d[bit_q - BW'(1)] = 1'b1;
                        bit_d                  = bit_q - BW'(1);
                        set_cnt_d              = '0;
                        state_d                = S_SETTLE;
                    end else begin
                        result_d = code_d;
                        state_d  = S_DONE;
                    end
                end else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 2)) begin
                    timeout_d = 1'b1;
                    code_d    = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            code_q       <= '0;
            bit_q        <= '0;
            set_cnt_q    <= '0;
            to_cnt_q     <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            meas_start_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            bit_q        <= bit_d;
            set_cnt_q    <= set_cnt_d;
            to_cnt_q     <= to_cnt_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            busy_q       <= state_d != S_IDLE;
            meas_start_q <= state_d == S_START;
            valid_q      <= state_d == S_DONE;
        end
    end

    assign o_dac_data     = code_q;
    assign o_dac_enable   = busy_q;
    assign o_busy         = busy_q;
    assign o_meas_start   = meas_start_q;
    assign o_result       = result_q;
    assign o_result_valid = valid_q;
    assign o_timeout      = timeout_q;
endmodule

// File: doc/tempsens_vdac_sar_ctrl.md
Name: tempsens_vdac_sar_ctrl

Overview:
- Successive-approximation controller directly upstream of the tempsens voltage DAC.
- Drives the DAC code and enable.
- For each trial code: waits for the DAC output to settle, triggers one delay-line measurement, then keeps or clears the trial bit based on the late/early verdict.
- Delivers the final DAC code as the temperature result to the readout logic.

Parameters:
- DAC_BITS, 6: width of the DAC code and of the result.
- SETTLE_CYCLES, 4: clock cycles the trial code is held before o_meas_start fires; legal range 1..255.
- TIMEOUT_CYCLES, 255: maximum cycles waiting for i_meas_done per trial before aborting; legal range 2..65535.

Ports:
- i_clk, input, 1: sole clock.
- i_reset, input, 1: asynchronous, active-high reset.
- i_start, input, 1: conversion request, sampled on the rising edge of i_clk.
- i_meas_done, input, 1: measurement complete, single-cycle pulse from the delay-line block.
- i_meas_late, input, 1: measurement verdict, valid only with i_meas_done. 1 means the delay exceeded the reference, i.e. the code must go higher.
- o_dac_data, output, DAC_BITS: code to the DAC i_data input.
- o_dac_enable, output, 1: to the DAC i_enable input.
- o_meas_start, output, 1: one-cycle trigger for the delay-line measurement.
- o_busy, output, 1: high in every state except IDLE.
- o_result, output, DAC_BITS: last successful conversion result, registered.
- o_result_valid, output, 1: one-cycle pulse when o_result updates.
- o_timeout, output, 1: sticky abort flag.

Behaviour:
- Reset, asynchronous: state IDLE; all counters 0; o_dac_data=0, o_dac_enable=0, o_meas_start=0, o_busy=0, o_result=0, o_result_valid=0, o_timeout=0.
- All outputs are registered; there is no combinational input-to-output path.

States:
- IDLE:
  - o_dac_enable=0; o_dac_data holds its last value.
  - i_start=1 -> SETTLE. Same edge: code register = 1<<(DAC_BITS-1), bit index = DAC_BITS-1, settle counter = 0, o_timeout cleared, o_dac_enable=1.
- SETTLE:
  - o_dac_data = trial code.
  - Counts SETTLE_CYCLES cycles, then -> START.
- START:
  - Exactly one cycle with o_meas_start=1. Timeout counter cleared; -> WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - i_meas_done=1, with bit index b:
    - Bit b of the code is kept if i_meas_late=1 and cleared otherwise.
    - If b>0: set bit b-1, decrement b, settle counter = 0, -> SETTLE.
    - If b=0: -> DONE.
  - Counter reaches TIMEOUT_CYCLES without done: o_timeout=1, o_dac_data=0, o_dac_enable=0 -> IDLE. o_result is unchanged and no valid pulse is issued.
  - Done and timeout in the same cycle: done wins.
- DONE:
  - o_result = final code; o_result_valid=1 for this one cycle; o_dac_data keeps the final code.
  - -> IDLE the next cycle.

Boundary rules:
- i_start while o_busy=1 is ignored; there is no restart.
- i_start held high re-triggers only from IDLE. A conversion restarts the cycle after DONE.
- i_meas_done outside WAIT is ignored. This includes the START cycle itself.
- o_timeout stays high until the next accepted i_start.
- Reset asserted mid-conversion aborts immediately to the reset values. o_result is reset to 0.

Timing:
- i_meas_done returns one cycle after o_meas_start (minimum measurement latency).
- o_result_valid then asserts DAC_BITS*(SETTLE_CYCLES+2)+1 cycles after the edge that accepted i_start.
- Default parameters: 37 cycles.

Test Plan:
1. Reset check: assert i_reset asynchronously mid-cycle -> all outputs 0 immediately. Release, hold i_start=0 for 10 cycles -> outputs stay 0 and o_busy=0.
2. Ideal responder with i_meas_late=(o_dac_data<=37), done one cycle after o_meas_start:
   - Trial codes 32, 48, 40, 36, 38, 37 appear on o_dac_data.
   - o_result=37; o_result_valid pulses once, exactly 37 cycles after start.
   - Exactly six o_meas_start pulses.
3. Extremes:
   - Responder always late -> o_result=63.
   - Responder never late -> o_result=0.
   - Both runs: o_dac_enable=1 only while o_busy=1.
4. Timeout: responder ignores the third o_meas_start.
   - o_timeout=1 exactly 255 cycles after that pulse; o_dac_enable=0; o_dac_data=0.
   - o_result keeps its previous value; no valid pulse.
   - Next i_start clears o_timeout.
5. Protocol abuse:
   - i_start pulsed during SETTLE and WAIT -> ignored, and the result matches scenario 2.
   - i_meas_done in SETTLE -> no code change.
   - i_meas_done coincident with the timeout cycle -> conversion continues with no timeout.
6. Mid-conversion reset: assert i_reset during the fourth WAIT -> IDLE and all outputs 0. A fresh i_start afterwards yields the correct result of 37.
